// File: rtl/jit_pkg.sv
// ---------------------------------------------------------------------------
// jit_pkg
// Shared definitions for the ARM template sequencer slice of the JIT path:
//   - default template-address / instruction widths
//   - UNSUPPORTED lookup sentinel (also the highest template address)
//   - bit offsets of the ext / last flags inside a template memory word
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package jit_pkg;

    localparam int unsigned JIT_TPL_AW = 7;
    localparam int unsigned JIT_ARM_W  = 32;

    // Lookup ROM result meaning "no template"; equals the top template address.
    localparam logic [JIT_TPL_AW-1:0] TPL_UNSUPPORTED = 7'h7F;

    // Template word layout: {ext, last, instruction[ARM_W-1:0]}
    localparam int unsigned LAST_BIT = JIT_ARM_W;
    localparam int unsigned EXT_BIT  = JIT_ARM_W + 1;

    // Encodings kept identical to the legacy localparam values.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EMIT   = 3'd3,
        ST_TRAP   = 3'd4
    } state_t;

endpackage

// File: rtl/arm_tpl_sequencer_if.sv
// ---------------------------------------------------------------------------
// arm_tpl_sequencer_if
// Bus bundle between the sequencer and its environment.
//   op_valid/op_ready/op_code      opcode handshake (env -> sequencer)
//   rom_idx/rom_adr                lookup ROM index and combinational result
//   tpl_adr/tpl_data               template memory address / sync-read word
//   arm_valid/arm_ready/arm_word/arm_last  emitted instruction stream
// Modports: master = sequencer side, slave = environment side.
// ---------------------------------------------------------------------------
interface arm_tpl_sequencer_if #(
    parameter int unsigned TPL_AW = 7,
    parameter int unsigned ARM_W  = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        op_code;
    logic [8:0]        rom_idx;
    logic [TPL_AW-1:0] rom_adr;
    logic [TPL_AW-1:0] tpl_adr;
    logic [ARM_W+1:0]  tpl_data;
    logic              arm_valid;
    logic              arm_ready;
    logic [ARM_W-1:0]  arm_word;
    logic              arm_last;

    modport master (
        input  op_valid, op_code, rom_adr, tpl_data, arm_ready,
        output op_ready, rom_idx, tpl_adr, arm_valid, arm_word, arm_last
    );

    modport slave (
        output op_valid, op_code, rom_adr, tpl_data, arm_ready,
        input  op_ready, rom_idx, tpl_adr, arm_valid, arm_word, arm_last
    );
endinterface

// File: rtl/jit_emit_stats.sv
// ---------------------------------------------------------------------------
// jit_emit_stats
// Free-running statistics for the template sequencer. Both counters wrap.
//   clk, rst_n     clock, async active-low reset (counters clear to 0)
//   beat_i         one accepted arm_valid && arm_ready beat
//   trap_i         one trap pulse
//   emit_cnt_o     accepted beat count (32 bit)
//   trap_cnt_o     trap pulse count (16 bit)
// ---------------------------------------------------------------------------
module jit_emit_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat_i,
    input  logic        trap_i,
    output logic [31:0] emit_cnt_o,
    output logic [15:0] trap_cnt_o
);
    logic [31:0] emit_cnt_q;
    logic [15:0] trap_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_cnt_q <= '0;
            trap_cnt_q <= '0;
        end else begin
            if (beat_i) emit_cnt_q <= emit_cnt_q + 32'd1;
            if (trap_i) trap_cnt_q <= trap_cnt_q + 16'd1;
        end
    end

    assign emit_cnt_o = emit_cnt_q;
    assign trap_cnt_o = trap_cnt_q;
endmodule

// File: rtl/arm_tpl_sequencer.sv
// ---------------------------------------------------------------------------
// arm_tpl_sequencer
// Takes one JVM opcode per handshake, looks up its ARM template start address
// through the external lookup ROM, then walks template memory emitting one
// ARM instruction per beat. A template word flagged ext (with last) in phase 0
// chains to a second lookup at index {1, op}. UNSUPPORTED lookups and walking
// past the top template address raise a one-cycle trap.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          arm_tpl_sequencer_if.master (opcode, ROM, template, output)
//   trap         one-cycle pulse on unsupported opcode / address overflow
//   emit_cnt     (JIT_EMIT_STATS_EN only) accepted beat count
//   trap_cnt     (JIT_EMIT_STATS_EN only) trap pulse count
//
// Build option: define JIT_EMIT_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module arm_tpl_sequencer #(
    parameter int unsigned TPL_AW = 7,
    parameter int unsigned ARM_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arm_tpl_sequencer_if.master    bus,
    output logic                   trap
`ifdef JIT_EMIT_STATS_EN
    ,
    output logic [31:0]            emit_cnt,
    output logic [15:0]            trap_cnt
`endif
);
    import jit_pkg::*;

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic              phase_q, phase_d;
    logic [TPL_AW-1:0] adr_q, adr_d;
    logic              rdy_q;

    logic              emit;
    logic              beat;
    logic              w_last;
    logic              w_ext;
    logic              chain;

    assign emit   = (state_q == ST_EMIT);
    assign beat   = emit && bus.arm_ready;
    assign w_last = bus.tpl_data[LAST_BIT];
    assign w_ext  = bus.tpl_data[EXT_BIT];
    // ext only chains out of phase 0; in phase 1 the sequence ends at last.
    assign chain  = w_ext && !phase_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        phase_d = phase_q;
        adr_d   = adr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && rdy_q) begin
                    op_d    = bus.op_code;
                    phase_d = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (bus.rom_adr == TPL_UNSUPPORTED) begin
                    state_d = ST_TRAP;
                end else begin
                    adr_d   = bus.rom_adr;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EMIT;
            ST_EMIT: begin
                if (beat) begin
                    if (!w_last) begin
                        if (adr_q == TPL_UNSUPPORTED) begin
                            state_d = ST_TRAP;
                        end else begin
                            adr_d   = adr_q + TPL_AW'(1);
                            state_d = ST_FETCH;
                        end
                    end else if (chain) begin
                        phase_d = 1'b1;
                        state_d = ST_LOOKUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            phase_q <= 1'b0;
            adr_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            adr_q   <= adr_d;
            // Registered ready: low through reset, high whenever IDLE is next.
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    assign bus.op_ready  = rdy_q;
    assign bus.rom_idx   = {phase_q, op_q};
    assign bus.tpl_adr   = adr_q;
    assign bus.arm_valid = emit;
    // Gated so the output is 0 outside EMIT regardless of memory contents.
    assign bus.arm_word  = emit ? bus.tpl_data[ARM_W-1:0] : '0;
    assign bus.arm_last  = emit && w_last && !chain;
    assign trap          = (state_q == ST_TRAP);

`ifdef JIT_EMIT_STATS_EN
    jit_emit_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_i     (beat),
        .trap_i     (trap),
        .emit_cnt_o (emit_cnt),
        .trap_cnt_o (trap_cnt)
    );
`endif
endmodule

// File: tb/tb_arm_tpl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arm_tpl_sequencer
// Self-checking bench: behavioural lookup ROM and template memory, directed
// cases followed by randomized opcodes/backpressure, each compared against a
// sequence model that walks the tables by the sequencing rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arm_tpl_sequencer;

    localparam int unsigned TPL_AW = 7;
    localparam int unsigned ARM_W  = 32;
    localparam int unsigned TB_LAST = 32;
    localparam int unsigned TB_EXT  = 33;

    logic clk;
    logic rst_n;
    logic trap;
`ifdef JIT_EMIT_STATS_EN
    logic [31:0] emit_cnt;
    logic [15:0] trap_cnt;
`endif

    arm_tpl_sequencer_if #(.TPL_AW(TPL_AW), .ARM_W(ARM_W)) bus ();

    arm_tpl_sequencer #(.TPL_AW(TPL_AW), .ARM_W(ARM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .trap     (trap)
`ifdef JIT_EMIT_STATS_EN
        ,
        .emit_cnt (emit_cnt),
        .trap_cnt (trap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [33:0] mem [0:127];
    logic [6:0]  rom [0:511];

    assign bus.rom_adr = rom[bus.rom_idx];
    always @(posedge clk) bus.tpl_data <= mem[bus.tpl_adr];

    int n_chk = 0;
    int n_err = 0;
    int exp_emit = 0;
    int exp_traps = 0;

    logic [31:0] exp_word [$];
    logic        exp_last [$];
    logic [6:0]  exp_adr  [$];
    logic        exp_trap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        return 32'($urandom);
    endfunction

    // Expected output of one opcode, derived from the table contents.
    task automatic build_expect(input logic [7:0] op);
        logic       ph;
        logic [6:0] a;
        logic [33:0] w;
        bit         fin;
        exp_word.delete();
        exp_last.delete();
        exp_adr.delete();
        exp_trap = 1'b0;
        ph  = 1'b0;
        a   = rom[{1'b0, op}];
        fin = 1'b0;
        if (a == 7'h7F) begin exp_trap = 1'b1; fin = 1'b1; end
        while (!fin) begin
            w = mem[a];
            exp_adr.push_back(a);
            exp_word.push_back(w[31:0]);
            if (!w[TB_LAST]) begin
                exp_last.push_back(1'b0);
                if (a == 7'h7F) begin exp_trap = 1'b1; fin = 1'b1; end
                else a = a + 7'd1;
            end else if (w[TB_EXT] && !ph) begin
                exp_last.push_back(1'b0);
                ph = 1'b1;
                a  = rom[{1'b1, op}];
                if (a == 7'h7F) begin exp_trap = 1'b1; fin = 1'b1; end
            end else begin
                exp_last.push_back(1'b1);
                fin = 1'b1;
            end
        end
    endtask

    task automatic fill_directed();
        for (int i = 0; i < 512; i++) rom[i] = 7'h7F;
        for (int i = 0; i < 128; i++) mem[i] = {2'b01, rnd_word()};
        rom[9'h022] = 7'd26;  mem[26]  = {2'b01, rnd_word()};
        rom[9'h00B] = 7'd11;  mem[11]  = {2'b00, rnd_word()};
                              mem[12]  = {2'b01, rnd_word()};
        rom[9'h041] = 7'd40;  mem[40]  = {2'b11, rnd_word()};
        rom[9'h141] = 7'h7F;
        rom[9'h050] = 7'h7E;  mem[126] = {2'b00, rnd_word()};
                              mem[127] = {2'b00, rnd_word()};
        rom[9'h060] = 7'd50;  mem[50]  = {2'b11, rnd_word()};
        rom[9'h160] = 7'd60;  mem[60]  = {2'b00, rnd_word()};
                              mem[61]  = {2'b11, rnd_word()};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
        for (int i = 0; i < 128; i++)
            mem[i] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rnd_word()};
    endtask

    // Offer one opcode and follow it to arm_last or trap. Called at a negedge.
    task automatic run_op(input logic [7:0] op, input int stall_n, input bit rnd_rdy);
        int          cyc;
        int          first_v;
        int          nbeat;
        int          stalls;
        int          guard;
        bit          done;
        bit          got_trap;
        bit          prev_stall;
        logic        rdy;
        logic [31:0] held_w;
        logic [6:0]  held_a;

        build_expect(op);
        guard = 0;
        while (!bus.op_ready && guard < 50) begin @(negedge clk); guard++; end
        chk("op_ready_before", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_code  = 8'($urandom);
        chk("lookup_idx", bus.rom_idx, {1'b0, op});
        chk("op_ready_busy", bus.op_ready, 0);

        cyc = 1; first_v = -1; nbeat = 0; stalls = 0;
        done = 0; got_trap = 0; prev_stall = 0;
        held_w = '0; held_a = '0;
        while (!done && cyc < 2000) begin
            if (prev_stall) begin
                chk("hold_valid", bus.arm_valid, 1);
                chk("hold_word", bus.arm_word, held_w);
                chk("hold_adr", bus.tpl_adr, held_a);
            end
            prev_stall = 0;
            if (trap) begin
                got_trap = 1;
                done = 1;
                chk("valid_in_trap", bus.arm_valid, 0);
            end else if (bus.arm_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalls < stall_n) rdy = 1'b0;
                else if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
                else rdy = 1'b1;
                bus.arm_ready = rdy;
                if (!rdy) begin
                    stalls++;
                    prev_stall = 1;
                    held_w = bus.arm_word;
                    held_a = bus.tpl_adr;
                end else begin
                    if (nbeat < exp_word.size()) begin
                        chk("beat_word", bus.arm_word, exp_word[nbeat]);
                        chk("beat_last", bus.arm_last, exp_last[nbeat]);
                        chk("beat_adr", bus.tpl_adr, exp_adr[nbeat]);
                    end else begin
                        chk("extra_beat", nbeat + 1, exp_word.size());
                        done = 1;
                    end
                    nbeat++;
                    if (bus.arm_last) done = 1;
                end
            end else begin
                bus.arm_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        chk("seq_end_seen", done, 1);
        chk("beat_count", nbeat, exp_word.size());
        chk("trap_seen", got_trap, exp_trap);
        if (exp_word.size() > 0) chk("first_latency", first_v, 3);
        chk("op_ready_after", bus.op_ready, 1);
        chk("trap_one_cycle", trap, 0);
        exp_emit  += exp_word.size();
        exp_traps += int'(exp_trap);
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_code   = '0;
        bus.arm_ready = 1'b0;
        fill_directed();
        repeat (2) @(negedge clk);
        chk("rst_op_ready", bus.op_ready, 0);
        chk("rst_rom_idx", bus.rom_idx, 0);
        chk("rst_tpl_adr", bus.tpl_adr, 0);
        chk("rst_arm_valid", bus.arm_valid, 0);
        chk("rst_arm_word", bus.arm_word, 0);
        chk("rst_arm_last", bus.arm_last, 0);
        chk("rst_trap", trap, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("op_ready_post_rst", bus.op_ready, 1);

        run_op(8'h22, 0, 0);   // single word, last
        run_op(8'h0B, 0, 0);   // two words 11, 12
        run_op(8'h0B, 5, 0);   // 5-cycle stall in EMIT
        run_op(8'h41, 0, 1);   // ext chain into UNSUPPORTED phase 1
        run_op(8'h50, 0, 1);   // walk to 7F with last=0 -> overflow trap
        run_op(8'h60, 2, 1);   // ext chain, ext ignored in phase 1
        run_op(8'h99, 0, 0);   // unsupported in phase 0
        run_op(8'h22, 0, 0);

        // Reset asserted mid-EMIT.
        bus.op_valid  = 1'b1;
        bus.op_code   = 8'h0B;
        bus.arm_ready = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b0;
        guard = 0;
        while (!bus.arm_valid && guard < 10) begin @(negedge clk); guard++; end
        chk("mid_rst_in_emit", bus.arm_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.arm_valid, 0);
        chk("mid_rst_trap", trap, 0);
        chk("mid_rst_op_ready", bus.op_ready, 0);
        chk("mid_rst_last", bus.arm_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_emit  = 0;
        exp_traps = 0;
        @(negedge clk);
        chk("post_rst_op_ready", bus.op_ready, 1);
        chk("post_rst_trap", trap, 0);
        run_op(8'h0B, 1, 0);

        fill_random();
        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), $urandom_range(0, 3), 1'b1);

`ifdef JIT_EMIT_STATS_EN
        chk("emit_cnt", emit_cnt, exp_emit);
        chk("trap_cnt", trap_cnt, exp_traps);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
